// File: rtl/cache_mon_pkg.sv
// Shared types and default sizing for the cache hit-rate monitor.
// Holds the FSM state enum, default parameter values and the snapshot record layout.
package cache_mon_pkg;

   localparam int DEF_CNT_W         = 16;
   localparam int DEF_WIN_W         = 20;
   localparam int DEF_WINDOW_CYCLES = 100000;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   // Snapshot record at default counter width (handy for readers/benches of a default build).
   typedef struct packed {
      logic [DEF_CNT_W-1:0] hits;
      logic [DEF_CNT_W-1:0] accesses;
      logic                 sat;
   } snap_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones and flags any increment it had to drop.
// count_next is the value after this cycle's increment, before any clear takes effect.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count_next,
   output logic         sat
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] count_reg;

   assign sat        = inc && (count_reg == MAX);
   assign count_next = (inc && !sat) ? count_reg + W'(1) : count_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/cache_hit_monitor.sv
// Counts accesses and cache hits over fixed windows and offers each window's totals
// on a valid/ready snapshot port, flagging saturation and unread-snapshot overflow.
module cache_hit_monitor
   import cache_mon_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int WIN_W         = DEF_WIN_W,
   parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic             clear,
   input  logic             acc_done,
   input  logic             found_in_cache,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic [CNT_W-1:0] snap_hits,
   output logic [CNT_W-1:0] snap_accesses,
   output logic             snap_overflow,
   output logic             sat_flag
);

   typedef struct packed {
      logic [CNT_W-1:0] hits;
      logic [CNT_W-1:0] accesses;
      logic             sat;
   } win_snap_t;

   localparam logic [WIN_W-1:0] LAST_TICK = WIN_W'(WINDOW_CYCLES - 1);

   // State follows enable directly, so an N-cycle enable gap freezes exactly N cycles.
   state_t state;
   logic   active;
   assign state  = enable ? COUNT : IDLE;
   assign active = (state == COUNT);

   logic [WIN_W-1:0] timer_reg;
   logic             window_end;
   logic             restart;
   logic             accept;

   assign window_end = active && (timer_reg == LAST_TICK) && !clear;
   assign restart    = clear || window_end;
   assign accept     = snap_valid && snap_ready;

   logic [CNT_W-1:0] hits_next;
   logic [CNT_W-1:0] acc_next;
   logic             hits_sat;
   logic             acc_sat;
   logic             sat_reg;

   sat_counter #(.W(CNT_W)) u_hits (
      .clk        (clk),
      .resetn     (resetn),
      .inc        (active && acc_done && found_in_cache),
      .clr        (restart),
      .count_next (hits_next),
      .sat        (hits_sat)
   );

   sat_counter #(.W(CNT_W)) u_accesses (
      .clk        (clk),
      .resetn     (resetn),
      .inc        (active && acc_done),
      .clr        (restart),
      .count_next (acc_next),
      .sat        (acc_sat)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_reg <= '0;
         sat_reg   <= 1'b0;
      end else if (restart) begin
         timer_reg <= '0;
         sat_reg   <= 1'b0;
      end else if (active) begin
         timer_reg <= timer_reg + WIN_W'(1);
         sat_reg   <= sat_reg | hits_sat | acc_sat;
      end
   end

   // The captured values include this cycle's event so nothing falls between windows.
   win_snap_t new_snap;
   win_snap_t snap_reg;
   logic      valid_reg;
   logic      overflow_reg;

   always_comb begin
      new_snap          = '0;
      new_snap.hits     = hits_next;
      new_snap.accesses = acc_next;
      new_snap.sat      = sat_reg | hits_sat | acc_sat;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         snap_reg     <= '0;
         valid_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (accept) begin
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
         end
         if (window_end) begin
            if (!valid_reg || accept) begin
               snap_reg  <= new_snap;
               valid_reg <= 1'b1;
            end else begin
               overflow_reg <= 1'b1;
            end
         end
      end
   end

   assign snap_valid    = valid_reg;
   assign snap_hits     = snap_reg.hits;
   assign snap_accesses = snap_reg.accesses;
   assign sat_flag      = snap_reg.sat;
   assign snap_overflow = overflow_reg;

endmodule

// File: tb/tb_cache_hit_monitor.sv
// Directed bench for cache_hit_monitor: a 10-cycle-window instance for the main
// scenarios and a 3-bit/16-cycle instance for counter saturation.
module tb_cache_hit_monitor;
   import cache_mon_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic enable = 1'b0;
   logic clear = 1'b0;
   logic acc_done = 1'b0;
   logic found_in_cache = 1'b0;
   logic snap_ready = 1'b0;

   logic        snap_valid;
   logic [15:0] snap_hits;
   logic [15:0] snap_accesses;
   logic        snap_overflow;
   logic        sat_flag;

   logic        s_valid;
   logic [2:0]  s_hits;
   logic [2:0]  s_acc;
   logic        s_ovf;
   logic        s_sat;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #50 clk = ~clk;

   cache_hit_monitor #(.CNT_W(16), .WIN_W(20), .WINDOW_CYCLES(10)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .enable         (enable),
      .clear          (clear),
      .acc_done       (acc_done),
      .found_in_cache (found_in_cache),
      .snap_valid     (snap_valid),
      .snap_ready     (snap_ready),
      .snap_hits      (snap_hits),
      .snap_accesses  (snap_accesses),
      .snap_overflow  (snap_overflow),
      .sat_flag       (sat_flag)
   );

   cache_hit_monitor #(.CNT_W(3), .WIN_W(20), .WINDOW_CYCLES(16)) dut_s (
      .clk            (clk),
      .resetn         (resetn),
      .enable         (enable),
      .clear          (clear),
      .acc_done       (acc_done),
      .found_in_cache (found_in_cache),
      .snap_valid     (s_valid),
      .snap_ready     (snap_ready),
      .snap_hits      (s_hits),
      .snap_accesses  (s_acc),
      .snap_overflow  (s_ovf),
      .sat_flag       (s_sat)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      enable = 1'b0; clear = 1'b0; acc_done = 1'b0;
      found_in_cache = 1'b0; snap_ready = 1'b0;
      repeat (2) step();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      snap_t got;
      resetn = 1'b0;
      #20;
      got = '{hits: snap_hits, accesses: snap_accesses, sat: sat_flag};
      total_cnt++;
      if (got !== snap_t'(0)) $display("FAIL reset_snap: got %h want 0", got); else pass_cnt++;
      total_cnt++;
      if (snap_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", snap_valid); else pass_cnt++;
      total_cnt++;
      if (snap_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", snap_overflow); else pass_cnt++;
      total_cnt++;
      if ({s_valid, s_hits, s_acc, s_ovf, s_sat} !== 9'd0)
         $display("FAIL reset_sat_inst: got %b want 0", {s_valid, s_hits, s_acc, s_ovf, s_sat});
      else pass_cnt++;
      $display("test_reset done");
   endtask

   task automatic test_window();
      do_reset();
      enable = 1'b1; acc_done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         found_in_cache = (i % 2 == 0);
         step();
         if (i == 8) begin
            total_cnt++;
            if (snap_valid !== 1'b0) $display("FAIL win_early: got valid=%b want 0", snap_valid); else pass_cnt++;
         end
      end
      total_cnt++;
      if (snap_valid !== 1'b1) $display("FAIL win_valid: got %b want 1", snap_valid); else pass_cnt++;
      total_cnt++;
      if (snap_accesses !== 16'd10 || snap_hits !== 16'd5 || sat_flag !== 1'b0)
         $display("FAIL win_data: got acc=%0d hits=%0d sat=%b want acc=10 hits=5 sat=0", snap_accesses, snap_hits, sat_flag);
      else pass_cnt++;
      enable = 1'b0; acc_done = 1'b0;
      $display("test_window: acc=%0d hits=%0d", snap_accesses, snap_hits);
   endtask

   task automatic test_saturation();
      do_reset();
      enable = 1'b1; acc_done = 1'b1; found_in_cache = 1'b1;
      repeat (16) step();
      total_cnt++;
      if (s_valid !== 1'b1) $display("FAIL sat_valid: got %b want 1", s_valid); else pass_cnt++;
      total_cnt++;
      if (s_hits !== 3'd7 || s_acc !== 3'd7 || s_sat !== 1'b1)
         $display("FAIL sat_data: got hits=%0d acc=%0d sat=%b want hits=7 acc=7 sat=1", s_hits, s_acc, s_sat);
      else pass_cnt++;
      enable = 1'b0; acc_done = 1'b0; found_in_cache = 1'b0;
      $display("test_saturation: hits=%0d acc=%0d sat=%b", s_hits, s_acc, s_sat);
   endtask

   task automatic test_overflow();
      do_reset();
      enable = 1'b1; found_in_cache = 1'b1;
      for (int i = 0; i < 10; i++) begin
         acc_done = (i % 2 == 0);
         step();
      end
      total_cnt++;
      if (snap_valid !== 1'b1 || snap_overflow !== 1'b0)
         $display("FAIL ovf_first: got valid=%b ovf=%b want valid=1 ovf=0", snap_valid, snap_overflow);
      else pass_cnt++;
      acc_done = 1'b1; found_in_cache = 1'b0;
      repeat (10) step();
      total_cnt++;
      if (snap_hits !== 16'd5 || snap_accesses !== 16'd5)
         $display("FAIL ovf_hold: got hits=%0d acc=%0d want hits=5 acc=5", snap_hits, snap_accesses);
      else pass_cnt++;
      total_cnt++;
      if (snap_overflow !== 1'b1 || snap_valid !== 1'b1)
         $display("FAIL ovf_flag: got ovf=%b valid=%b want ovf=1 valid=1", snap_overflow, snap_valid);
      else pass_cnt++;
      enable = 1'b0; acc_done = 1'b0; snap_ready = 1'b1;
      step();
      snap_ready = 1'b0;
      total_cnt++;
      if (snap_valid !== 1'b0 || snap_overflow !== 1'b0)
         $display("FAIL ovf_accept: got valid=%b ovf=%b want valid=0 ovf=0", snap_valid, snap_overflow);
      else pass_cnt++;
      $display("test_overflow done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      enable = 1'b1; acc_done = 1'b1; found_in_cache = 1'b1;
      repeat (10) step();
      found_in_cache = 1'b0;
      for (int i = 0; i < 10; i++) begin
         acc_done = (i < 3);
         snap_ready = (i == 9);
         step();
         if (i == 8) begin
            total_cnt++;
            if (snap_hits !== 16'd10 || snap_accesses !== 16'd10)
               $display("FAIL b2b_old: got hits=%0d acc=%0d want hits=10 acc=10", snap_hits, snap_accesses);
            else pass_cnt++;
         end
      end
      snap_ready = 1'b0; enable = 1'b0; acc_done = 1'b0;
      total_cnt++;
      if (snap_valid !== 1'b1 || snap_overflow !== 1'b0)
         $display("FAIL b2b_valid: got valid=%b ovf=%b want valid=1 ovf=0", snap_valid, snap_overflow);
      else pass_cnt++;
      total_cnt++;
      if (snap_hits !== 16'd0 || snap_accesses !== 16'd3)
         $display("FAIL b2b_data: got hits=%0d acc=%0d want hits=0 acc=3", snap_hits, snap_accesses);
      else pass_cnt++;
      $display("test_back_to_back: hits=%0d acc=%0d", snap_hits, snap_accesses);
   endtask

   task automatic test_enable_gap();
      do_reset();
      acc_done = 1'b1; found_in_cache = 1'b1;
      enable = 1'b1;
      repeat (4) step();
      enable = 1'b0;
      repeat (5) step();
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i == 4) begin
            total_cnt++;
            if (snap_valid !== 1'b0) $display("FAIL gap_early: got valid=%b want 0", snap_valid); else pass_cnt++;
         end
      end
      total_cnt++;
      if (snap_valid !== 1'b1) $display("FAIL gap_valid: got %b want 1", snap_valid); else pass_cnt++;
      total_cnt++;
      if (snap_accesses !== 16'd10 || snap_hits !== 16'd10)
         $display("FAIL gap_data: got acc=%0d hits=%0d want acc=10 hits=10", snap_accesses, snap_hits);
      else pass_cnt++;
      enable = 1'b0; acc_done = 1'b0; found_in_cache = 1'b0;
      $display("test_enable_gap: acc=%0d", snap_accesses);
   endtask

   task automatic test_clear();
      do_reset();
      enable = 1'b1; acc_done = 1'b1;
      repeat (9) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      total_cnt++;
      if (snap_valid !== 1'b0) $display("FAIL clear_wins: got valid=%b want 0", snap_valid); else pass_cnt++;
      repeat (10) step();
      total_cnt++;
      if (snap_valid !== 1'b1 || snap_accesses !== 16'd10)
         $display("FAIL clear_restart: got valid=%b acc=%0d want valid=1 acc=10", snap_valid, snap_accesses);
      else pass_cnt++;
      enable = 1'b0; acc_done = 1'b0;
      $display("test_clear done");
   endtask

   task automatic test_reset_mid_window();
      do_reset();
      enable = 1'b1; acc_done = 1'b1;
      repeat (3) step();
      acc_done = 1'b0;
      repeat (2) step();
      #20 resetn = 1'b0;
      #10;
      total_cnt++;
      if (snap_valid !== 1'b0 || snap_accesses !== 16'd0)
         $display("FAIL rst_mid: got valid=%b acc=%0d want valid=0 acc=0", snap_valid, snap_accesses);
      else pass_cnt++;
      step();
      resetn = 1'b1;
      acc_done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         found_in_cache = (i % 2 == 1);
         step();
         if (i == 8) begin
            total_cnt++;
            if (snap_valid !== 1'b0) $display("FAIL rst_no_snap: got valid=%b want 0", snap_valid); else pass_cnt++;
         end
      end
      total_cnt++;
      if (snap_valid !== 1'b1 || snap_accesses !== 16'd10 || snap_hits !== 16'd5 || snap_overflow !== 1'b0)
         $display("FAIL rst_next_win: got valid=%b acc=%0d hits=%0d ovf=%b want 1/10/5/0",
                  snap_valid, snap_accesses, snap_hits, snap_overflow);
      else pass_cnt++;
      enable = 1'b0; acc_done = 1'b0;
      $display("test_reset_mid_window: acc=%0d", snap_accesses);
   endtask

   initial begin
      test_reset();
      test_window();
      test_saturation();
      test_overflow();
      test_back_to_back();
      test_enable_gap();
      test_clear();
      test_reset_mid_window();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
